// File: rtl/param_queue.sv
// rtl/param_queue.sv - parameterised circular-buffer queue with registered read and threshold/sticky flags
// One-cycle read latency, no write-to-read bypass, clr flushes without touching storage or rd_data.
module param_queue #(
   parameter int WIDTH    = 33,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       rd_valid,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT  = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_CNT  = CW'(AE_LEVEL);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             rd_acc;
   logic             wr_acc;

   assign full         = (count == CNT_MAX);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_CNT);
   assign almost_empty = (count <= AE_CNT);

   // A write into a full queue is legal only when a read frees the head slot this cycle.
   assign rd_acc = rd_en && !empty;
   assign wr_acc = wr_en && (!full || rd_acc);

   // Storage is never reset; the rst/clr gating keeps flushed or reset edges from storing.
   always_ff @(posedge clk) begin
      if (wr_acc && !clr && !rst) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rd_valid  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         rd_valid <= rd_acc;
         if (rd_acc) begin
            rd_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + PTR_ONE;
         end
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (wr_en && !wr_acc) begin
            overflow <= 1'b1;
         end
         if (rd_en && !rd_acc) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: doc/param_queue.md
PARAM_QUEUE -- requirements
Module: param_queue

Interface
REQ-001 Parameter WIDTH, default 33, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, number of entries; power of two, >=2.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, occupancy at or above which almost_full asserts.
REQ-004 Parameter AE_LEVEL, default 1, occupancy at or below which almost_empty asserts.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 clr  input  1  synchronous flush request.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_data  input  WIDTH  write word.
REQ-010 rd_en  input  1  read request.
REQ-011 rd_data  output  WIDTH  registered read word.
REQ-012 rd_valid  output  1  rd_data updated by a read accepted on the previous edge.
REQ-013 full, empty  output  1 each  occupancy==DEPTH, occupancy==0.
REQ-014 almost_full, almost_empty  output  1 each  threshold flags.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Storage SHALL be a circular buffer with write/read pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-018 A read SHALL be accepted iff rd_en && !empty; it SHALL load rd_data with the head entry, advance the read pointer, and set rd_valid=1 for exactly one cycle.
REQ-019 A write SHALL be accepted iff wr_en && (!full || read accepted in the same cycle); it SHALL store wr_data at the write pointer and advance it.
REQ-020 Full with rd_en and wr_en in the same cycle: both accepted, count stays DEPTH, full stays 1.
REQ-021 Empty with rd_en and wr_en in the same cycle: write accepted, read rejected (no bypass), count becomes 1, underflow set, rd_valid=0 next cycle.
REQ-022 Non-full, non-empty with both: both accepted, count unchanged.
REQ-023 Read latency SHALL be one cycle: data accepted at edge N is on rd_data after edge N, held until the next accepted read.
REQ-024 Write-to-read latency: a word written at edge N SHALL be readable from edge N+1 (empty deasserts after edge N).
REQ-025 count SHALL be +1 on write-only, -1 on read-only, unchanged otherwise; flags are combinational decodes of count.
REQ-026 overflow SHALL set when wr_en is rejected; underflow SHALL set when rd_en is rejected; both hold until clr or rst.
REQ-027 clr SHALL take priority over wr_en/rd_en in the same cycle: pointers and count to 0, overflow/underflow to 0, rd_valid to 0; rd_data holds; no write stored.
REQ-028 Storage contents SHALL not be reset; only pointers, count, flags and output registers are.

Reset
REQ-029 rst assertion SHALL act immediately, regardless of clk: count=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_data=0, rd_valid=0, overflow=0, underflow=0, pointers=0.
REQ-030 rst mid-operation SHALL discard all queued entries; after deassertion the first read returns the first word written after reset.
REQ-031 No write or read SHALL be accepted on an edge at which rst is high.

Verification (WIDTH=33, DEPTH=8, defaults)
REQ-032 Reset then write 25, idle, read -> rd_data=25 and rd_valid=1 one cycle after read edge; empty=1, count=0.
REQ-033 Write 1..8 -> full=1, almost_full=1 from count 6; 9th write (99) rejected, overflow=1; reads return 1..8 in order, pointers wrap.
REQ-034 Full, simultaneous write 78 and read -> rd_data=1, count=8; after draining, 78 is last word out.
REQ-035 Empty, simultaneous write 738 and read -> rd_valid=0, underflow=1, count=1; next read returns 738.
REQ-036 Count=5, clr with wr_en=1 -> count=0, empty=1, overflow/underflow=0, rd_data unchanged; subsequent read sets underflow.
REQ-037 rst pulsed asynchronously between edges at count=3 -> outputs at reset values before next edge; post-reset write 7/read returns 7.
